// File: rtl/link_word_packer.sv
// Packs RATIO narrow link words (IN_W bits) into one wide word with valid/ready on both sides.
// Optional per-lane even parity output is enabled with `define PACK_LANE_PARITY_EN.
module link_word_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int LW       = $clog2(RATIO)
) (
    input  logic             div_8_clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
`ifdef PACK_LANE_PARITY_EN
    output logic [RATIO-1:0] out_par,
`endif
    output logic             out_last
);

    logic             r_run;
    logic [OUT_W-1:0] r_acc;
    logic [RATIO-1:0] r_acc_keep;
    logic [LW-1:0]    r_lane_idx;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [RATIO-1:0] r_out_keep;
    logic             r_out_last;

    logic             w_accept;
    logic             w_complete;
    logic [LW-1:0]    w_lane_pos;
    logic [OUT_W-1:0] w_acc_merged;
    logic [RATIO-1:0] w_keep_merged;

    // r_run keeps in_ready low while reset is held and lifts it on the first edge after release.
    assign in_ready   = r_run && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_lane_pos = LSB_FIRST ? r_lane_idx : (LW'(RATIO - 1) - r_lane_idx);
    assign w_complete = w_accept && (in_last || (r_lane_idx == LW'(RATIO - 1)));

    always_comb begin
        w_acc_merged  = r_acc;
        w_keep_merged = r_acc_keep;
        w_acc_merged[w_lane_pos*IN_W +: IN_W] = in_data;
        w_keep_merged[w_lane_pos]             = 1'b1;
    end

    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_lane_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_merged;
                r_out_keep  <= w_keep_merged;
                r_out_last  <= in_last;
                r_acc       <= '0;
                r_acc_keep  <= '0;
                r_lane_idx  <= '0;
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc      <= w_acc_merged;
                    r_acc_keep <= w_keep_merged;
                    r_lane_idx <= r_lane_idx + LW'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

`ifdef PACK_LANE_PARITY_EN
    logic [RATIO-1:0] w_par_next;
    logic [RATIO-1:0] r_out_par;

    // Unfilled lanes are zero in the merged word, so their parity is 0 without masking.
    always_comb begin
        w_par_next = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_par_next[i] = ^w_acc_merged[i*IN_W +: IN_W];
        end
    end

    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            r_out_par <= '0;
        end else if (w_complete) begin
            r_out_par <= w_par_next;
        end
    end

    assign out_par = r_out_par;
`endif

endmodule

// File: tb/tb_link_word_packer.sv
// Directed bench for link_word_packer: an LSB-first and an MSB-first instance share stimulus,
// each with its own expected-word queue popped on every output handshake.
module tb_link_word_packer;
    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
    localparam int EW    = 1 + RATIO + OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;

    logic a_in_ready, a_out_valid, a_out_last;
    logic [OUT_W-1:0] a_out_data;
    logic [RATIO-1:0] a_out_keep;
    logic b_in_ready, b_out_valid, b_out_last;
    logic [OUT_W-1:0] b_out_data;
    logic [RATIO-1:0] b_out_keep;
`ifdef PACK_LANE_PARITY_EN
    logic [RATIO-1:0] a_out_par, b_out_par;
`endif

    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int g;

    always #5 clk = ~clk;

    link_word_packer #(.IN_W(IN_W), .RATIO(RATIO), .LSB_FIRST(1'b1)) dut_a (
        .div_8_clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_keep(a_out_keep),
`ifdef PACK_LANE_PARITY_EN
        .out_par(a_out_par),
`endif
        .out_last(a_out_last)
    );

    link_word_packer #(.IN_W(IN_W), .RATIO(RATIO), .LSB_FIRST(1'b0)) dut_b (
        .div_8_clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_keep(b_out_keep),
`ifdef PACK_LANE_PARITY_EN
        .out_par(b_out_par),
`endif
        .out_last(b_out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        check_cnt++;
        fail_cnt++;
        $error("FAIL %s", tag);
    endtask

    // Present one beat at a negedge and hold it until the packer accepts it.
    task automatic send(input logic [IN_W-1:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (a_in_ready !== 1'b1 && guard <= 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 200) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic l, input logic [RATIO-1:0] ka, input logic [OUT_W-1:0] da,
                        input logic [RATIO-1:0] kb, input logic [OUT_W-1:0] db);
        exp_a_q.push_back({l, ka, da});
        exp_b_q.push_back({l, kb, db});
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            if (exp_a_q.size() == 0) fail_now("a_unexpected_word");
            else chk("a_word", {a_out_last, a_out_keep, a_out_data}, exp_a_q.pop_front());
        end
        if (!rst && b_out_valid && out_ready) begin
            if (exp_b_q.size() == 0) fail_now("b_unexpected_word");
            else chk("b_word", {b_out_last, b_out_keep, b_out_data}, exp_b_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_a_out_keep", a_out_keep, 0);
        chk("rst_a_out_last", a_out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", a_in_ready, 1);
        out_ready = 1'b1;

        // Full word, no in_last
        push(1'b0, 4'b1111, 32'h44332211, 4'b1111, 32'h11223344);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("t1_latency_valid", a_out_valid, 1);

        // Partial frame closed by in_last
        push(1'b1, 4'b0011, 32'h0000BBAA, 4'b1100, 32'hAABB0000);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);

        // Output stall while input keeps streaming
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(1'b0, 4'b1111, 32'h04030201, 4'b1111, 32'h01020304);
        push(1'b0, 4'b1111, 32'h08070605, 4'b1111, 32'h05060708);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
            end
            begin
                g = 0;
                while (a_out_valid !== 1'b1 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                chk("t3_word_pending", a_out_valid, 1);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("t3_hold_data", a_out_data, 32'h04030201);
                    chk("t3_hold_in_ready", a_in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset with an undrained output word
        out_ready = 1'b0;
        send(8'hC3, 1'b1);
        chk("t4_pending_valid", a_out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_pending_valid", a_out_valid, 0);
        chk("t4_rst_pending_keep", a_out_keep, 0);
        chk("t4_rst_pending_last", a_out_last, 0);
        chk("t4_rst_in_ready", a_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset mid-frame after two beats
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_frame_a_valid", a_out_valid, 0);
        chk("t4_rst_frame_b_valid", b_out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        push(1'b0, 4'b1111, 32'h88776655, 4'b1111, 32'h55667788);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);

        // in_last on lane 0, back-to-back with drain and reload
        push(1'b1, 4'b0001, 32'h000000E7, 4'b1000, 32'hE7000000);
        push(1'b1, 4'b0001, 32'h000000F1, 4'b1000, 32'hF1000000);
        send(8'hE7, 1'b1);
        send(8'hF1, 1'b1);
        chk("t5_no_bubble_valid", a_out_valid, 1);
        chk("t5_reload_data", a_out_data, 32'h000000F1);

        // in_last on the final lane
        push(1'b1, 4'b1111, 32'h40302010, 4'b1111, 32'h10203040);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b1);

`ifdef PACK_LANE_PARITY_EN
        push(1'b0, 4'b1111, 32'h00070301, 4'b1111, 32'h01030700);
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        send(8'h00, 1'b0);
        chk("par_a", a_out_par, 4'b0101);
        chk("par_b", b_out_par, 4'b1010);
`endif

        g = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("queues_drained", exp_a_q.size() + exp_b_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
